// File: rtl/reg_op_seq.sv
// Two-operand execute sequencer for a 16x4 register array: reads two sources
// serially through the single read port, applies a 4-bit ALU op, writes back.
module reg_op_seq (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [3:0] srcA,
   input  logic [3:0] srcB,
   input  logic [3:0] dst,
   output logic       busy,
   output logic       done,
   output logic [3:0] result,
   output logic       carry,
   output logic       zero,
   output logic [3:0] rfReadAddr,
   input  logic [3:0] rfDataOut,
   output logic [3:0] rfWriteAddr,
   output logic       rfWriteEnable,
   output logic [3:0] rfDataIn
);

   localparam int unsigned DW = 4;
   localparam int unsigned AW = 4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   typedef enum logic [1:0] {IDLE, RDA, RDB, WB} state_t;

   state_t        state, state_n;
   logic [1:0]    op_q, op_n;
   logic [AW-1:0] srcb_q, srcb_n;
   logic [DW-1:0] opa_q, opa_n;
   logic [DW-1:0] result_n;
   logic          carry_n, zero_n;
   logic [AW-1:0] raddr_n, waddr_n;
   logic          busy_n, done_n, we_q, we_n;
   logic [DW:0]   sum, diff;

   // 5-bit arithmetic so carry/borrow fall out of the top bit
   assign sum  = {1'b0, opa_q} + {1'b0, rfDataOut};
   assign diff = {1'b0, opa_q} - {1'b0, rfDataOut};

   always_comb begin
      state_n  = state;
      op_n     = op_q;
      srcb_n   = srcb_q;
      opa_n    = opa_q;
      result_n = result;
      carry_n  = carry;
      zero_n   = zero;
      raddr_n  = rfReadAddr;
      waddr_n  = rfWriteAddr;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = RDA;
               op_n    = op;
               srcb_n  = srcB;
               waddr_n = dst;
               raddr_n = srcA;
            end
         end
         RDA: begin
            opa_n = rfDataOut;
            if (op_q == 2'b11) begin
               result_n = rfDataOut;
               carry_n  = 1'b0;
               zero_n   = (rfDataOut == '0);
               state_n  = WB;
            end else begin
               raddr_n = srcb_q;
               state_n = RDB;
            end
         end
         RDB: begin
            case (op_q)
               OP_ADD:  {carry_n, result_n} = sum;
               OP_SUB:  {carry_n, result_n} = diff;
               OP_AND: begin
                  result_n = opa_q & rfDataOut;
                  carry_n  = 1'b0;
               end
               default: begin
                  result_n = opa_q;
                  carry_n  = 1'b0;
               end
            endcase
            zero_n  = (result_n == '0);
            state_n = WB;
         end
         WB:      state_n = IDLE;
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
      done_n = (state_n == WB);
      we_n   = (state_n == WB);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state       <= IDLE;
         op_q        <= '0;
         srcb_q      <= '0;
         opa_q       <= '0;
         result      <= '0;
         carry       <= 1'b0;
         zero        <= 1'b0;
         rfReadAddr  <= '0;
         rfWriteAddr <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         we_q        <= 1'b0;
      end else begin
         state       <= state_n;
         op_q        <= op_n;
         srcb_q      <= srcb_n;
         opa_q       <= opa_n;
         result      <= result_n;
         carry       <= carry_n;
         zero        <= zero_n;
         rfReadAddr  <= raddr_n;
         rfWriteAddr <= waddr_n;
         busy        <= busy_n;
         done        <= done_n;
         we_q        <= we_n;
      end
   end

   // Gate with clr so a reset landing in WB suppresses that edge's array write
   assign rfWriteEnable = we_q & ~clr;
   assign rfDataIn      = result;

endmodule

// File: tb/tb_reg_op_seq.sv
// Directed bench for reg_op_seq with a behavioural 16x4 register array.
module tb_reg_op_seq;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] AND = 2'b10;
   localparam logic [1:0] MOV = 2'b11;

   logic       clk = 1'b0;
   logic       clr, start;
   logic [1:0] op;
   logic [3:0] srcA, srcB, dst;
   logic       busy, done, carry, zero, rfWriteEnable;
   logic [3:0] result, rfReadAddr, rfDataOut, rfWriteAddr, rfDataIn;

   logic [3:0] mem [16];
   int         wr_cnt = 0;
   int         n_cmp  = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   reg_op_seq dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
      .dst(dst), .busy(busy), .done(done), .result(result), .carry(carry),
      .zero(zero), .rfReadAddr(rfReadAddr), .rfDataOut(rfDataOut),
      .rfWriteAddr(rfWriteAddr), .rfWriteEnable(rfWriteEnable), .rfDataIn(rfDataIn)
   );

   assign rfDataOut = mem[rfReadAddr];

   always @(posedge clk) begin
      if (rfWriteEnable) begin
         mem[rfWriteAddr] <= rfDataIn;
         wr_cnt <= wr_cnt + 1;
      end
   end

   typedef struct {
      logic [1:0] op;
      logic [3:0] sa, sb, d, va, vb, res;
      logic       c, z;
      int         lat;
   } vec_t;

   vec_t vecs [10];

   function automatic vec_t mk(logic [1:0] o, logic [3:0] sa, logic [3:0] sb, logic [3:0] d,
                               logic [3:0] va, logic [3:0] vb, logic [3:0] res,
                               logic c, logic z, int lat);
      vec_t v;
      v.op = o; v.sa = sa; v.sb = sb; v.d = d; v.va = va; v.vb = vb;
      v.res = res; v.c = c; v.z = z; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " result"}, int'(result), 0);
      chk({tag, " carry"}, int'(carry), 0);
      chk({tag, " zero"}, int'(zero), 0);
      chk({tag, " rfReadAddr"}, int'(rfReadAddr), 0);
      chk({tag, " rfWriteAddr"}, int'(rfWriteAddr), 0);
      chk({tag, " rfWriteEnable"}, int'(rfWriteEnable), 0);
      chk({tag, " rfDataIn"}, int'(rfDataIn), 0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int w0, lat;
      string t;
      t = $sformatf("vec%0d", idx);
      mem[v.sa] = v.va;
      mem[v.sb] = v.vb;
      if (v.d != v.sa && v.d != v.sb) mem[v.d] = ~v.res;
      w0 = wr_cnt;
      op = v.op; srcA = v.sa; srcB = v.sb; dst = v.d; start = 1'b1;
      step();
      // scramble inputs after acceptance; must not affect the operation
      start = 1'b0; op = ~v.op; srcA = ~v.sa; srcB = ~v.sb; dst = ~v.d;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         if (done) begin
            lat = k;
            break;
         end
         step();
      end
      chk({t, " latency"}, lat, v.lat);
      if (lat != 0) begin
         chk({t, " result"}, int'(result), int'(v.res));
         chk({t, " carry"}, int'(carry), int'(v.c));
         chk({t, " zero"}, int'(zero), int'(v.z));
         chk({t, " we"}, int'(rfWriteEnable), 1);
         chk({t, " waddr"}, int'(rfWriteAddr), int'(v.d));
         chk({t, " raddr"}, int'(rfReadAddr), int'((v.op == MOV) ? v.sa : v.sb));
         step();
         chk({t, " mem[dst]"}, int'(mem[v.d]), int'(v.res));
         chk({t, " writes"}, wr_cnt - w0, 1);
         chk({t, " busy idle"}, int'(busy), 0);
      end
   endtask

   initial begin
      int w0, nd;
      clr = 1'b1; start = 1'b0; op = '0; srcA = '0; srcB = '0; dst = '0;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      vecs[0] = mk(ADD, 4'd3, 4'd7, 4'd2, 4'd5,  4'd9,  4'd14, 1'b0, 1'b0, 3);
      vecs[1] = mk(ADD, 4'd3, 4'd7, 4'd2, 4'd9,  4'd8,  4'd1,  1'b1, 1'b0, 3);
      vecs[2] = mk(SUB, 4'd3, 4'd7, 4'd2, 4'd3,  4'd5,  4'd14, 1'b1, 1'b0, 3);
      vecs[3] = mk(SUB, 4'd3, 4'd7, 4'd2, 4'd5,  4'd5,  4'd0,  1'b0, 1'b1, 3);
      vecs[4] = mk(AND, 4'd4, 4'd5, 4'd6, 4'hC,  4'hA,  4'h8,  1'b0, 1'b0, 3);
      vecs[5] = mk(MOV, 4'd4, 4'd5, 4'd9, 4'hC,  4'hA,  4'hC,  1'b0, 1'b0, 2);
      vecs[6] = mk(ADD, 4'd1, 4'd1, 4'd1, 4'd7,  4'd7,  4'd14, 1'b0, 1'b0, 3);
      vecs[7] = mk(ADD, 4'd8, 4'd9, 4'd10, 4'd8, 4'd8,  4'd0,  1'b1, 1'b1, 3);
      vecs[8] = mk(SUB, 4'd0, 4'd15, 4'd11, 4'd0, 4'd1, 4'd15, 1'b1, 1'b0, 3);
      vecs[9] = mk(MOV, 4'd12, 4'd13, 4'd12, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 2);

      repeat (2) step();
      chk_all_zero("reset");
      clr = 1'b0;
      step();

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // reset held two cycles starting in RDB of an ADD aborts the write
      mem[3] = 4'd5; mem[7] = 4'd9; mem[2] = 4'hF;
      op = ADD; srcA = 4'd3; srcB = 4'd7; dst = 4'd2; start = 1'b1;
      step();
      start = 1'b0;
      step();
      w0 = wr_cnt;
      clr = 1'b1;
      step();
      chk_all_zero("midreset");
      step();
      clr = 1'b0;
      step();
      chk("midreset busy after", int'(busy), 0);
      chk("midreset mem[2]", int'(mem[2]), 15);
      chk("midreset writes", wr_cnt - w0, 0);

      // start pulsed during RDA is ignored
      mem[1] = 4'd7;
      w0 = wr_cnt; nd = 0;
      op = ADD; srcA = 4'd1; srcB = 4'd1; dst = 4'd1; start = 1'b1;
      step();
      op = SUB; srcA = 4'd2; dst = 4'd3;
      step();
      start = 1'b0;
      if (done) nd++;
      for (int k = 0; k < 8; k++) begin
         step();
         if (done) nd++;
      end
      chk("ignore done count", nd, 1);
      chk("ignore mem[1]", int'(mem[1]), 14);
      chk("ignore writes", wr_cnt - w0, 1);

      // start held high: three accumulating ADDs into R3
      mem[3] = 4'd1; mem[7] = 4'd2;
      w0 = wr_cnt; nd = 0;
      op = ADD; srcA = 4'd3; srcB = 4'd7; dst = 4'd3; start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         step();
         if (k == 9) start = 1'b0;
         if (done) begin
            nd++;
            chk($sformatf("b2b done%0d cycle", nd), k, 4 * nd - 1);
            chk($sformatf("b2b done%0d result", nd), int'(result), 2 * nd + 1);
         end
      end
      chk("b2b done count", nd, 3);
      chk("b2b mem[3]", int'(mem[3]), 7);
      chk("b2b writes", wr_cnt - w0, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
